// File: rtl/lc3b_regfile_sb.sv
// LC-3b register file: 8 x 16-bit registers, pending-write scoreboard,
// NZP condition codes, and a sticky flag for malformed write enables.
module lc3b_regfile_sb #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrValid,
    input  logic [NREG-1:0]  wrEnOneHot,
    input  logic [WIDTH-1:0] wrData,
    input  logic             ldCC,
    input  logic [SEL_W-1:0] rdSelA,
    input  logic [SEL_W-1:0] rdSelB,
    output logic [WIDTH-1:0] rdDataA,
    output logic [WIDTH-1:0] rdDataB,
    output logic             busyA,
    output logic             busyB,
    input  logic             issueValid,
    input  logic [SEL_W-1:0] issueDst,
    output logic             issueStall,
    output logic [NREG-1:0]  busyVec,
    output logic [2:0]       nzp,
    output logic             wrErr
);

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic [2:0]       r_nzp;
    logic             r_wr_err;

    logic             w_onehot;
    logic             w_wr_ok;
    logic             w_wr_bad;
    logic             w_issue_ok;
    logic [NREG-1:0]  w_wr_vec;
    logic [NREG-1:0]  w_issue_vec;
    logic [NREG-1:0]  w_busy_nxt;

    // Condition codes derived from a 16-bit two's-complement result
    function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] d);
        if (d[WIDTH-1])
            return 3'b100;
        else if (d == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Qualify the writeback enable and decode the accepted issue destination
    always_comb begin
        w_onehot    = (wrEnOneHot != '0) &&
                      ((wrEnOneHot & (wrEnOneHot - {{(NREG-1){1'b0}}, 1'b1})) == '0);
        w_wr_ok     = wrValid & w_onehot;
        w_wr_bad    = wrValid & ~w_onehot;
        w_wr_vec    = w_wr_ok ? wrEnOneHot : '0;
        w_issue_ok  = issueValid & ~r_busy[issueDst];
        w_issue_vec = '0;
        if (w_issue_ok)
            w_issue_vec[issueDst] = 1'b1;
        // Writeback clears busy, issue sets it; set wins on the same register
        w_busy_nxt  = (r_busy & ~w_wr_vec) | w_issue_vec;
    end

    // Register array, scoreboard, condition codes and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy   <= '0;
            r_nzp    <= 3'b010;
            r_wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_wr_vec[i])
                    r_regs[i] <= wrData;
            r_busy <= w_busy_nxt;
            if (w_wr_ok && ldCC)
                r_nzp <= calc_nzp(wrData);
            if (w_wr_bad)
                r_wr_err <= 1'b1;
        end
    end

    // Zero-latency reads with same-cycle writeback bypass; busy has no bypass
    always_comb begin
        rdDataA    = w_wr_vec[rdSelA] ? wrData : r_regs[rdSelA];
        rdDataB    = w_wr_vec[rdSelB] ? wrData : r_regs[rdSelB];
        busyA      = r_busy[rdSelA];
        busyB      = r_busy[rdSelB];
        issueStall = issueValid & r_busy[issueDst];
        busyVec    = r_busy;
        nzp        = r_nzp;
        wrErr      = r_wr_err;
    end

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Directed testbench for lc3b_regfile_sb.
module tb_lc3b_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrValid;
    logic [7:0]  wrEnOneHot;
    logic [15:0] wrData;
    logic        ldCC;
    logic [2:0]  rdSelA, rdSelB;
    logic [15:0] rdDataA, rdDataB;
    logic        busyA, busyB;
    logic        issueValid;
    logic [2:0]  issueDst;
    logic        issueStall;
    logic [7:0]  busyVec;
    logic [2:0]  nzp;
    logic        wrErr;

    int checks = 0;
    int errors = 0;

    lc3b_regfile_sb dut (
        .clk(clk), .reset(reset), .wrValid(wrValid), .wrEnOneHot(wrEnOneHot),
        .wrData(wrData), .ldCC(ldCC), .rdSelA(rdSelA), .rdSelB(rdSelB),
        .rdDataA(rdDataA), .rdDataB(rdDataB), .busyA(busyA), .busyB(busyB),
        .issueValid(issueValid), .issueDst(issueDst), .issueStall(issueStall),
        .busyVec(busyVec), .nzp(nzp), .wrErr(wrErr)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read one register via port A with writeback idle
    task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        rdSelA = sel;
        #1;
        chk(tag, {16'h0, rdDataA}, {16'h0, exp});
    endtask

    task automatic idle();
        wrValid = 0; wrEnOneHot = 8'h00; wrData = 16'h0; ldCC = 0;
        issueValid = 0; issueDst = 3'd0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rdSelA = 0; rdSelB = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            rdSelA = 3'(i); rdSelB = 3'(7 - i);
            #1;
            chk($sformatf("rst_rdA%0d", i), {16'h0, rdDataA}, 32'h0);
            chk($sformatf("rst_rdB%0d", i), {16'h0, rdDataB}, 32'h0);
        end
        chk("rst_busyVec", {24'h0, busyVec}, 32'h00);
        chk("rst_nzp", {29'h0, nzp}, 32'b010);
        chk("rst_wrErr", {31'h0, wrErr}, 32'h0);

        // Negative write to reg5 with bypass on port A
        wrValid = 1; wrEnOneHot = 8'b0010_0000; wrData = 16'h8001; ldCC = 1;
        rdSelA = 5; rdSelB = 4;
        #1;
        chk("bypassA", {16'h0, rdDataA}, 32'h8001);
        chk("nobypassB", {16'h0, rdDataB}, 32'h0000);
        tick();
        idle();
        rd_chk("reg5", 3'd5, 16'h8001);
        chk("nzp_neg", {29'h0, nzp}, 32'b100);

        // Zero to reg3, then positive to reg1
        wrValid = 1; wrEnOneHot = 8'b0000_1000; wrData = 16'h0000; ldCC = 1;
        tick();
        idle();
        chk("nzp_zero", {29'h0, nzp}, 32'b010);
        wrValid = 1; wrEnOneHot = 8'b0000_0010; wrData = 16'h1234; ldCC = 1;
        rdSelB = 1;
        #1;
        chk("bypassB", {16'h0, rdDataB}, 32'h1234);
        tick();
        idle();
        chk("nzp_pos", {29'h0, nzp}, 32'b001);
        rd_chk("reg1", 3'd1, 16'h1234);

        // Issue dst=2, re-issue stalls, writeback clears
        issueValid = 1; issueDst = 2;
        #1;
        chk("issue_nostall", {31'h0, issueStall}, 32'h0);
        tick();
        idle();
        rdSelA = 2;
        #1;
        chk("busyVec_iss2", {24'h0, busyVec}, 32'h04);
        chk("busyA_2", {31'h0, busyA}, 32'h1);
        issueValid = 1; issueDst = 2;
        #1;
        chk("issue_stall", {31'h0, issueStall}, 32'h1);
        tick();
        idle();
        chk("busyVec_stall", {24'h0, busyVec}, 32'h04);
        wrValid = 1; wrEnOneHot = 8'b0000_0100; wrData = 16'h5555; ldCC = 0;
        rdSelA = 2;
        #1;
        chk("busyA_nobypass", {31'h0, busyA}, 32'h1);
        tick();
        idle();
        chk("busyVec_wb2", {24'h0, busyVec}, 32'h00);
        chk("nzp_noldcc", {29'h0, nzp}, 32'b001);
        rd_chk("reg2", 3'd2, 16'h5555);

        // Issue and writeback to the same register: set wins, data written
        issueValid = 1; issueDst = 4;
        wrValid = 1; wrEnOneHot = 8'b0001_0000; wrData = 16'hBEEF; ldCC = 0;
        tick();
        idle();
        rd_chk("reg4", 3'd4, 16'hBEEF);
        chk("busyVec_setwins", {24'h0, busyVec}, 32'h10);

        // Issue and writeback to different registers
        issueValid = 1; issueDst = 6;
        wrValid = 1; wrEnOneHot = 8'b0000_0001; wrData = 16'h00AA; ldCC = 0;
        tick();
        idle();
        rd_chk("reg0", 3'd0, 16'h00AA);
        chk("busyVec_both", {24'h0, busyVec}, 32'h50);
        rdSelB = 6;
        #1;
        chk("busyB_6", {31'h0, busyB}, 32'h1);

        // Malformed write: two bits set
        wrValid = 1; wrEnOneHot = 8'b0001_1000; wrData = 16'hFFFF; ldCC = 1;
        rdSelA = 3;
        #1;
        chk("bad_nobypass", {16'h0, rdDataA}, 32'h0000);
        tick();
        idle();
        rd_chk("bad_reg3", 3'd3, 16'h0000);
        rd_chk("bad_reg4", 3'd4, 16'hBEEF);
        chk("bad_nzp", {29'h0, nzp}, 32'b001);
        chk("bad_wrErr", {31'h0, wrErr}, 32'h1);
        chk("bad_busyVec", {24'h0, busyVec}, 32'h50);

        // Malformed write: no bits set
        wrValid = 1; wrEnOneHot = 8'b0000_0000; wrData = 16'hFFFF; ldCC = 1;
        tick();
        idle();
        rd_chk("zero_reg0", 3'd0, 16'h00AA);
        chk("zero_nzp", {29'h0, nzp}, 32'b001);

        // wrValid low: enable, data and ldCC ignored
        wrValid = 0; wrEnOneHot = 8'b0000_0010; wrData = 16'hDEAD; ldCC = 1;
        tick();
        idle();
        rd_chk("novalid_reg1", 3'd1, 16'h1234);
        chk("novalid_nzp", {29'h0, nzp}, 32'b001);
        chk("wrErr_sticky", {31'h0, wrErr}, 32'h1);

        // Reset wins over a simultaneous write and issue
        reset = 1;
        wrValid = 1; wrEnOneHot = 8'b1000_0000; wrData = 16'h7777; ldCC = 1;
        issueValid = 1; issueDst = 7;
        tick();
        reset = 0;
        idle();
        for (int i = 0; i < 8; i++)
            rd_chk($sformatf("rst2_reg%0d", i), 3'(i), 16'h0000);
        chk("rst2_busyVec", {24'h0, busyVec}, 32'h00);
        chk("rst2_nzp", {29'h0, nzp}, 32'b010);
        chk("rst2_wrErr", {31'h0, wrErr}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
